// File: rtl/systolic_output_drain.sv
// systolic_output_drain
// Snapshots a finished systolic_array result into a shadow register and streams it
// out one row per beat over valid/ready, so the array can start its next job while
// the previous result is still draining.
module systolic_output_drain #(
  parameter int rows     = 64,
  parameter int cols     = 64,
  parameter int op_width = 32,
  localparam int row_w   = (rows > 1) ? $clog2(rows) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          compute_done,
  input  logic [31:0]                   cycles_count,
  input  logic [rows*cols*op_width-1:0] output_matrix,
  input  logic                          clr_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [cols*op_width-1:0]      out_data,
  output logic [row_w-1:0]              out_row,
  output logic                          out_last,
  output logic                          busy,
  output logic                          drain_done,
  output logic                          overrun,
  output logic [31:0]                   latched_cycles
);

  localparam int beat_w = cols * op_width;
  localparam logic [row_w-1:0] last_row = row_w'(rows - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                         state;
  state_t                         state_nxt;
  logic                           done_q;
  logic [row_w-1:0]               row_idx;
  logic [row_w-1:0]               row_nxt;
  logic [rows*cols*op_width-1:0]  shadow;
  logic                           start;
  logic                           xfer;
  logic                           last_xfer;
  logic                           capture;
  logic                           ovr_set;

  // A new job is the rising edge of the done level, so a held level starts one drain.
  assign start     = compute_done & ~done_q;
  assign busy      = (state == DRAIN);
  assign out_valid = busy;
  assign out_row   = row_idx;
  assign out_last  = busy & (row_idx == last_row);
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & out_last;

  // Next-state and control: job acceptance, row advance, overrun detection.
  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    capture   = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRAIN;
          capture   = 1'b1;
          row_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          // A start landing on the final transfer is taken back-to-back.
          row_nxt = '0;
          if (start) begin
            capture   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (xfer) begin
            row_nxt = row_idx + row_w'(1);
          end else begin
            row_nxt = row_idx;
          end
          // Any other start while draining loses that job.
          if (start) begin
            ovr_set = 1'b1;
          end else begin
            ovr_set = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        row_nxt   = '0;
      end
    endcase
  end

  // State, edge-detect history, row pointer and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      done_q         <= 1'b0;
      row_idx        <= '0;
      drain_done     <= 1'b0;
      overrun        <= 1'b0;
      latched_cycles <= 32'd0;
    end else begin
      state      <= state_nxt;
      done_q     <= compute_done;
      row_idx    <= row_nxt;
      drain_done <= last_xfer;
      // Set has priority over the clear when both happen together.
      overrun    <= ovr_set | (overrun & ~clr_err);
      if (capture) begin
        latched_cycles <= cycles_count;
      end
    end
  end

  // Shadow copy of the result; only written when a job is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
    end else if (capture) begin
      shadow <= output_matrix;
    end
  end

  // Beat selection from the shadow; forced to zero whenever no beat is offered.
  always_comb begin
    out_data = '0;
    if (busy) begin
      out_data = shadow[int'(row_idx) * beat_w +: beat_w];
    end else begin
      out_data = '0;
    end
  end

endmodule
